// File: rtl/hdc_win_pkg.sv
// Shared constants and state type for the window stream controller.
// Window geometry, index widths and the sequencing FSM state enum.
package hdc_win_pkg;

    localparam int NUM_CHS     = 17;
    localparam int WINDOW_SIZE = 256;
    localparam int SAMPLE_SIZE = 16;

    localparam int SIDX_W = $clog2(WINDOW_SIZE);
    localparam int CIDX_W = $clog2(NUM_CHS);
    localparam int BEATS  = WINDOW_SIZE * NUM_CHS;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        STREAM,
        DRAIN
    } state_t;

endpackage

// File: rtl/window_stream_ctrl_if.sv
// Encoder beat stream: read indices, valid/ready, first/last/abort, done.
// master = window_stream_ctrl, slave = HDC encoder (plus external data mux).
interface window_stream_ctrl_if;
    import hdc_win_pkg::*;

    logic [SIDX_W-1:0] rd_sample_idx;
    logic [CIDX_W-1:0] rd_ch_idx;
    logic              enc_valid;
    logic              enc_ready;
    logic              enc_first;
    logic              enc_last;
    logic              enc_abort;
    logic              enc_done;

    modport master (
        output rd_sample_idx,
        output rd_ch_idx,
        output enc_valid,
        output enc_first,
        output enc_last,
        output enc_abort,
        input  enc_ready,
        input  enc_done
    );

    modport slave (
        input  rd_sample_idx,
        input  rd_ch_idx,
        input  enc_valid,
        input  enc_first,
        input  enc_last,
        input  enc_abort,
        output enc_ready,
        output enc_done
    );

endinterface

// File: rtl/win_beat_counter.sv
// 2-D (sample, channel) beat counter, channel inner, sample outer.
// Ports: clk, nrst, clear, advance in; sample_idx, ch_idx, first, last out.
module win_beat_counter
    import hdc_win_pkg::*;
(
    input  logic              clk,
    input  logic              nrst,
    input  logic              clear,
    input  logic              advance,
    output logic [SIDX_W-1:0] sample_idx,
    output logic [CIDX_W-1:0] ch_idx,
    output logic              first,
    output logic              last
);

    localparam logic [CIDX_W-1:0] CH_MAX = CIDX_W'(NUM_CHS - 1);
    localparam logic [SIDX_W-1:0] S_MAX  = SIDX_W'(WINDOW_SIZE - 1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sample_idx <= '0;
            ch_idx     <= '0;
        end else if (clear) begin
            sample_idx <= '0;
            ch_idx     <= '0;
        end else if (advance) begin
            if (ch_idx == CH_MAX) begin
                ch_idx     <= '0;
                sample_idx <= (sample_idx == S_MAX) ? '0
                                                    : sample_idx + 1'b1;
            end else begin
                ch_idx <= ch_idx + 1'b1;
            end
        end
    end

    assign first = (sample_idx == '0) && (ch_idx == '0);
    assign last  = (sample_idx == S_MAX) && (ch_idx == CH_MAX);

endmodule

// File: rtl/window_stream_ctrl.sv
// Sequences window buffer shifts and streams each completed window to the
// HDC encoder beat by beat; flags overrun when a new window lands early.
// Ports: clk, nrst, run, sample_valid, win_en, win_done, enc (master
// modport: indices, valid/ready, first/last/abort, done), busy, overrun,
// win_count; drop_count only when WSC_DROP_CNT_EN is defined.
module window_stream_ctrl
    import hdc_win_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                run,
    input  logic                sample_valid,
    output logic                win_en,
    input  logic                win_done,
    window_stream_ctrl_if.master enc,
    output logic                busy,
    output logic                overrun,
    output logic [15:0]         win_count
`ifdef WSC_DROP_CNT_EN
    ,
    output logic [15:0]         drop_count
`endif
);

    state_t state;
    state_t state_nxt;

    logic              cnt_clear;
    logic              cnt_adv;
    logic              cnt_first;
    logic              cnt_last;
    logic [SIDX_W-1:0] cnt_sidx;
    logic [CIDX_W-1:0] cnt_cidx;
    logic              ovr_evt;
    logic              done_evt;
    logic              abort_q;

    win_beat_counter u_cnt (
        .clk        (clk),
        .nrst       (nrst),
        .clear      (cnt_clear),
        .advance    (cnt_adv),
        .sample_idx (cnt_sidx),
        .ch_idx     (cnt_cidx),
        .first      (cnt_first),
        .last       (cnt_last)
    );

    // In STREAM enc_valid is always high, so ready alone means a transfer.
    // A new window during STREAM/DRAIN wins over any beat or enc_done.
    always_comb begin
        state_nxt = state;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        ovr_evt   = 1'b0;
        done_evt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) state_nxt = ARMED;
            end
            ARMED: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else if (win_done) begin
                    state_nxt = STREAM;
                    cnt_clear = 1'b1;
                end
            end
            STREAM: begin
                if (win_done) begin
                    ovr_evt   = 1'b1;
                    cnt_clear = 1'b1;
                end else if (enc.enc_ready) begin
                    cnt_adv = 1'b1;
                    if (cnt_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (win_done) begin
                    ovr_evt   = 1'b1;
                    cnt_clear = 1'b1;
                    state_nxt = STREAM;
                end else if (enc.enc_done) begin
                    done_evt  = 1'b1;
                    state_nxt = run ? ARMED : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            abort_q   <= 1'b0;
            overrun   <= 1'b0;
            win_count <= '0;
        end else begin
            state   <= state_nxt;
            abort_q <= ovr_evt;
            if (ovr_evt) overrun <= 1'b1;
            if (done_evt) win_count <= win_count + 16'd1;
        end
    end

`ifdef WSC_DROP_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drop_count <= '0;
        end else if (ovr_evt && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

    assign win_en = sample_valid & run;
    assign busy   = (state == STREAM) || (state == DRAIN);

    assign enc.enc_valid     = (state == STREAM);
    assign enc.rd_sample_idx = cnt_sidx;
    assign enc.rd_ch_idx     = cnt_cidx;
    assign enc.enc_first     = (state == STREAM) && cnt_first;
    assign enc.enc_last      = (state == STREAM) && cnt_last;
    assign enc.enc_abort     = abort_q;

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Testbench for window_stream_ctrl: vector table, directed corner
// sequences and random traffic checked against a beat-index model.
module tb_window_stream_ctrl;
    import hdc_win_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        run = 1'b0;
    logic        sample_valid = 1'b0;
    logic        win_done = 1'b0;
    logic        win_en;
    logic        busy;
    logic        overrun;
    logic [15:0] win_count;
`ifdef WSC_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    window_stream_ctrl_if enc_if();

    window_stream_ctrl dut (
        .clk          (clk),
        .nrst         (nrst),
        .run          (run),
        .sample_valid (sample_valid),
        .win_en       (win_en),
        .win_done     (win_done),
        .enc          (enc_if.master),
        .busy         (busy),
        .overrun      (overrun),
        .win_count    (win_count)
`ifdef WSC_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_STREAM = 2;
    localparam int M_DRAIN  = 3;

    int m_phase;
    int m_beat;
    bit m_ovr;
    bit m_abort;
    int m_wins;
    int m_drops;

    typedef struct {
        bit r;
        bit sv;
        bit wd;
        bit rdy;
        bit ed;
        bit x_en;
        bit x_val;
        int x_s;
        int x_c;
        bit x_first;
        bit x_busy;
    } vec_t;

    vec_t tv[9];

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cur_beat();
        return int'(enc_if.rd_sample_idx) * NUM_CHS + int'(enc_if.rd_ch_idx);
    endfunction

    task automatic model_reset();
        m_phase = M_IDLE;
        m_beat  = 0;
        m_ovr   = 0;
        m_abort = 0;
        m_wins  = 0;
        m_drops = 0;
    endtask

    // Window progress is a single linear beat number 0..BEATS-1.
    task automatic model_edge();
        m_abort = 0;
        if (m_phase == M_IDLE) begin
            if (run) m_phase = M_ARMED;
        end else if (m_phase == M_ARMED) begin
            if (!run) m_phase = M_IDLE;
            else if (win_done) begin
                m_phase = M_STREAM;
                m_beat  = 0;
            end
        end else if (win_done) begin
            m_ovr   = 1;
            m_abort = 1;
            m_beat  = 0;
            m_phase = M_STREAM;
            if (m_drops < 65535) m_drops++;
        end else if (m_phase == M_STREAM) begin
            if (enc_if.enc_ready) begin
                if (m_beat == BEATS - 1) m_phase = M_DRAIN;
                else m_beat++;
            end
        end else if (enc_if.enc_done) begin
            m_wins  = (m_wins + 1) % 65536;
            m_phase = run ? M_ARMED : M_IDLE;
        end
    endtask

    task automatic compare_all();
        bit v;
        v = (m_phase == M_STREAM);
        chk("valid", enc_if.enc_valid, v);
        if (v) begin
            chk("sidx", int'(enc_if.rd_sample_idx), m_beat / NUM_CHS);
            chk("cidx", int'(enc_if.rd_ch_idx), m_beat % NUM_CHS);
        end
        chk("first", enc_if.enc_first, v && (m_beat == 0));
        chk("last", enc_if.enc_last, v && (m_beat == BEATS - 1));
        chk("abort", enc_if.enc_abort, m_abort);
        chk("busy", busy, m_phase >= M_STREAM);
        chk("overrun", overrun, m_ovr);
        chk("win_count", int'(win_count), m_wins);
`ifdef WSC_DROP_CNT_EN
        chk("drop_count", int'(drop_count), m_drops);
`endif
    endtask

    task automatic cyc();
        #1;
        chk("win_en", win_en, run & sample_valid);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        run = 0;
        sample_valid = 0;
        win_done = 0;
        enc_if.enc_ready = 0;
        enc_if.enc_done = 0;
        #2;
        nrst = 0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        nrst = 1;
    endtask

    task automatic run_to_beat(int tgt);
        enc_if.enc_ready = 1;
        for (int k = 0; k < 6000; k++) begin
            if (enc_if.enc_valid && cur_beat() == tgt) break;
            cyc();
        end
        chk("reach_beat", cur_beat(), tgt);
    endtask

    initial begin
        int nb;
        int bad;
        enc_if.enc_ready = 0;
        enc_if.enc_done = 0;
        model_reset();

        tv[0] = '{0, 1, 1, 0, 0, 0, 0, -1, -1, 0, 0};
        tv[1] = '{1, 1, 0, 0, 0, 1, 0, -1, -1, 0, 0};
        tv[2] = '{1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1};
        tv[3] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        tv[4] = '{1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        tv[5] = '{0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 1};
        tv[6] = '{0, 1, 0, 0, 0, 0, 1, 0, 2, 0, 1};
        tv[7] = '{1, 0, 0, 1, 1, 0, 1, 0, 3, 0, 1};
        tv[8] = '{1, 0, 0, 1, 0, 0, 1, 0, 4, 0, 1};

        do_reset();
        chk("rst_valid", enc_if.enc_valid, 0);
        chk("rst_wcnt", int'(win_count), 0);

        foreach (tv[i]) begin
            run = tv[i].r;
            sample_valid = tv[i].sv;
            win_done = tv[i].wd;
            enc_if.enc_ready = tv[i].rdy;
            enc_if.enc_done = tv[i].ed;
            #1;
            chk("tv_en", win_en, tv[i].x_en);
            cyc();
            chk("tv_valid", enc_if.enc_valid, tv[i].x_val);
            chk("tv_first", enc_if.enc_first, tv[i].x_first);
            chk("tv_busy", busy, tv[i].x_busy);
            if (tv[i].x_s >= 0) begin
                chk("tv_sidx", int'(enc_if.rd_sample_idx), tv[i].x_s);
                chk("tv_cidx", int'(enc_if.rd_ch_idx), tv[i].x_c);
            end
        end

        // nominal full window at full rate
        do_reset();
        sample_valid = 0;
        enc_if.enc_done = 0;
        run = 1;
        cyc();
        win_done = 1;
        enc_if.enc_ready = 1;
        cyc();
        win_done = 0;
        nb = 0;
        bad = 0;
        for (int k = 0; k < 5000 && enc_if.enc_valid; k++) begin
            if (cur_beat() != nb) bad++;
            if (nb == 0) chk("nom_first", enc_if.enc_first, 1);
            if (nb == BEATS - 1) begin
                chk("nom_last", enc_if.enc_last, 1);
                chk("nom_last_s", int'(enc_if.rd_sample_idx), 255);
                chk("nom_last_c", int'(enc_if.rd_ch_idx), 16);
            end
            nb++;
            cyc();
        end
        chk("nom_beats", nb, 4352);
        chk("nom_order", bad, 0);
        chk("nom_drain", busy, 1);
        enc_if.enc_done = 1;
        cyc();
        enc_if.enc_done = 0;
        chk("nom_wcnt", int'(win_count), 1);
        chk("nom_armed", busy, 0);

        // backpressure 1,0,0,1 over 40 cycles => 20 beats
        win_done = 1;
        cyc();
        win_done = 0;
        for (int k = 0; k < 40; k++) begin
            enc_if.enc_ready = (k % 4 == 0) || (k % 4 == 3);
            cyc();
        end
        chk("bp_sidx", int'(enc_if.rd_sample_idx), 1);
        chk("bp_cidx", int'(enc_if.rd_ch_idx), 3);

        // overrun at beat 1000
        do_reset();
        run = 1;
        cyc();
        win_done = 1;
        cyc();
        win_done = 0;
        run_to_beat(1000);
        win_done = 1;
        cyc();
        win_done = 0;
        chk("ovr_abort", enc_if.enc_abort, 1);
        chk("ovr_flag", overrun, 1);
        chk("ovr_sidx", int'(enc_if.rd_sample_idx), 0);
        chk("ovr_cidx", int'(enc_if.rd_ch_idx), 0);
        chk("ovr_first", enc_if.enc_first, 1);
`ifdef WSC_DROP_CNT_EN
        chk("ovr_drops", int'(drop_count), 1);
`endif
        enc_if.enc_ready = 0;
        cyc();
        chk("ovr_abort_end", enc_if.enc_abort, 0);
        chk("ovr_sticky", overrun, 1);

        // run dropped mid-stream: finish window then idle
        run = 0;
        enc_if.enc_ready = 1;
        for (int k = 0; k < 5000 && enc_if.enc_valid; k++) cyc();
        chk("rd_drain", busy, 1);
        chk("rd_valid", enc_if.enc_valid, 0);
        enc_if.enc_done = 1;
        cyc();
        enc_if.enc_done = 0;
        chk("rd_wcnt", int'(win_count), 1);
        chk("rd_idle", busy, 0);
        win_done = 1;
        sample_valid = 1;
        #1;
        chk("rd_win_en", win_en, 0);
        cyc();
        win_done = 0;
        sample_valid = 0;
        chk("rd_ignored", enc_if.enc_valid, 0);

        // async reset at beat 500
        run = 1;
        cyc();
        win_done = 1;
        cyc();
        win_done = 0;
        run_to_beat(500);
        #2;
        nrst = 0;
        #1;
        chk("ar_valid", enc_if.enc_valid, 0);
        chk("ar_sidx", int'(enc_if.rd_sample_idx), 0);
        chk("ar_cidx", int'(enc_if.rd_ch_idx), 0);
        chk("ar_busy", busy, 0);
        chk("ar_ovr", overrun, 0);
        chk("ar_wcnt", int'(win_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        nrst = 1;
        run = 1;
        cyc();
        win_done = 1;
        cyc();
        win_done = 0;
        chk("ar_restart_s", int'(enc_if.rd_sample_idx), 0);
        chk("ar_restart_c", int'(enc_if.rd_ch_idx), 0);
        chk("ar_restart_f", enc_if.enc_first, 1);

        // random traffic
        do_reset();
        run = 1;
        for (int k = 0; k < 20000; k++) begin
            if (run) begin
                if ($urandom_range(2999) == 0) run = 0;
            end else if ($urandom_range(19) == 0) begin
                run = 1;
            end
            sample_valid = 1'($urandom_range(1));
            if (m_phase >= M_STREAM) win_done = ($urandom_range(7999) == 0);
            else win_done = ($urandom_range(49) == 0);
            enc_if.enc_ready = ($urandom_range(3) != 0);
            enc_if.enc_done = ($urandom_range(7) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
